odd_bit_decoder: RTL and testbench
==================================

# odd_bit_decoder

Stream decoder that turns a 2-bit odd-bit position code plus a majority value back into a 3-bit word. It is the inverse of the team's 3-bit odd-one-out classifier. It sits on the regeneration and test-stimulus side of the triple-redundancy path. Input and output use valid/ready handshakes with a 2-entry elastic buffer between them, and a saturating counter tracks how many accepted codes carried a mismatch.

## Interface
Parameters:
- CNT_W, 8, width of the mismatch counter (legal range 2..16)

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  input word offered
- in_ready  output  1  block can accept; high when the buffer is not full
- in_code  input  2  odd-bit position code
- in_maj  input  1  majority (common) bit value
- out_valid  output  1  decoded word available; high when the buffer is not empty
- out_ready  input  1  downstream accepts the word
- out  output  3  decoded word
- err_cnt  output  CNT_W  saturating count of accepted codes other than 2'b11
- err_seen  output  1  sticky; set on the first accepted code other than 2'b11
- clr  input  1  synchronous clear of err_cnt and err_seen

## Operation
- Code meaning, output written MSB first as out[2:0]:
  - 2'b00: bit0 differs
  - 2'b01: bit1 differs
  - 2'b10: bit2 differs
  - 2'b11: all bits equal
- Decode rule: out = {3{maj}} XOR onehot(code). onehot(11) = 3'b000.
- Decode examples:
  - code 00, maj 1 -> 3'b110
  - code 01, maj 1 -> 3'b101
  - code 10, maj 0 -> 3'b100
  - code 11, maj 0 -> 3'b000
- Decoding is applied at buffer write. Entries store the 3-bit word.
- Buffer is a 2-entry FIFO with write pointer, read pointer and 2-bit occupancy. Pointers are 1 bit and wrap 1 -> 0.
- Push: in_valid && in_ready. Pop: out_valid && out_ready.
- in_ready = (occupancy != 2). No combinational path from out_ready to in_ready.
- Simultaneous push and pop at occupancy 1: occupancy stays 1 and pointers both advance.
- At occupancy 0 only a push can occur. At occupancy 2 only a pop can occur.
- Word order is strictly FIFO.
- out is driven from the read-pointer entry. It is don't-care while out_valid is low, but the value must be stable.
- Counter: on push with code != 11, err_cnt increments and saturates at 2^CNT_W-1. err_seen is set.
- clr has priority over a same-cycle increment: the result is 0 and err_seen stays 0.
- Reset mid-operation discards buffered words. Values in flight are lost with no flush.

## Timing
- Reset values: in_ready 0 while rst_n is low, then 1; out_valid 0; out 3'b000; err_cnt 0; err_seen 0; pointers and occupancy 0.
- Latency: a word pushed at edge N gives out_valid=1 in the cycle after edge N. There is no same-cycle bypass.
- Throughput: 1 word/cycle sustained when out_ready is held high.
- Backpressure:
  - out_valid and out must hold until popped.
  - in_valid, in_code and in_maj are sampled only on push.
- err_cnt and err_seen update on the edge of the push. They are visible in the next cycle.

## Structure
- Shared package odd_bit_pkg holds:
  - code localparams CODE_B0=2'b00, CODE_B1=2'b01, CODE_B2=2'b10, CODE_NONE=2'b11
  - function onehot3(code)
- The classifier side imports the same package.
- Sub-module odd_bit_fifo2: the 2-entry, 3-bit-wide buffer with pointers and occupancy.
- Decode logic and the counter live in the top-level module.

## Test plan
- Reset, then push all 8 {code, maj} combinations with out_ready=1. Required outputs in order: 110, 001, 101, 010, 011, 100, 111, 000. err_cnt=6 and err_seen=1 at the end.
- Hold out_ready=0 and offer 3 words. in_ready drops after 2 pushes and the third is not accepted. Release out_ready: words drain in order and the third is accepted on the next cycle.
- At occupancy 1, push code 01 maj 1 and pop in the same cycle. Occupancy stays 1 and the next out is 3'b101.
- With CNT_W=2, push 5 mismatch codes: err_cnt saturates at 3. Then assert clr together with a mismatch push: err_cnt=0 and err_seen=0.
- Reset mid-stream at occupancy 2: out_valid=0 and err_cnt=0 on the next cycle, and the old words never appear.
- Randomized back-to-back traffic with a reference model. Round-trip check: feed each out into the classifier and confirm it returns the original code.

Source files
------------

// File: rtl/odd_bit_pkg.sv
// Shared odd-bit code definitions, used by both the classifier and the decoder.
package odd_bit_pkg;

  localparam int unsigned CODE_W = 2;
  localparam int unsigned WORD_W = 3;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam code_t CODE_B0   = 2'b00;
  localparam code_t CODE_B1   = 2'b01;
  localparam code_t CODE_B2   = 2'b10;
  localparam code_t CODE_NONE = 2'b11;

  // Bit that differs from the majority; all-equal maps to no flip.
  function automatic word_t onehot3(input code_t code);
    word_t oh;
    case (code)
      CODE_B0: oh = 3'b001;
      CODE_B1: oh = 3'b010;
      CODE_B2: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/odd_bit_decoder_if.sv
// Code-in / word-out stream bundle with valid/ready on both sides.
interface odd_bit_decoder_if;
  import odd_bit_pkg::*;

  logic  in_valid;
  logic  in_ready;
  code_t in_code;
  logic  in_maj;
  logic  out_valid;
  logic  out_ready;
  word_t out;

  modport master (
    output in_valid, in_code, in_maj, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in_code, in_maj, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/odd_bit_fifo2.sv
// Two-entry elastic buffer of decoded words; 1-bit pointers plus occupancy.
module odd_bit_fifo2
  import odd_bit_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  word_t wdata_i,
  input  logic  pop_i,
  output word_t rdata_o,
  output logic  not_full_o,
  output logic  not_empty_o
);

  localparam int unsigned OCC_W = 2;

  word_t [1:0]      mem_q, mem_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // Push and pop together leave the occupancy unchanged.
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign rdata_o     = mem_q[rd_ptr_q];
  assign not_full_o  = (occ_q != OCC_W'(2));
  assign not_empty_o = (occ_q != OCC_W'(0));

endmodule

// File: rtl/odd_bit_decoder.sv
// Rebuilds a 3-bit word from {odd-bit code, majority}, buffers it, and counts mismatch codes.
module odd_bit_decoder
  import odd_bit_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  odd_bit_decoder_if.slave bus,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_seen
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             push, pop;
  logic             not_full, not_empty;
  word_t            word_dec;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_seen_q, err_seen_d;

  // Ready is held low throughout reset regardless of buffer state.
  assign bus.in_ready  = rst_n && not_full;
  assign bus.out_valid = not_empty;
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign word_dec      = {WORD_W{bus.in_maj}} ^ onehot3(bus.in_code);

  odd_bit_fifo2 u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .wdata_i     (word_dec),
    .pop_i       (pop),
    .rdata_o     (bus.out),
    .not_full_o  (not_full),
    .not_empty_o (not_empty)
  );

  // Clear wins over a same-cycle mismatch push.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_seen_d = err_seen_q;
    if (clr) begin
      err_cnt_d  = '0;
      err_seen_d = 1'b0;
    end else if (push && (bus.in_code != CODE_NONE)) begin
      err_seen_d = 1'b1;
      if (err_cnt_q != CNT_MAX) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q  <= '0;
      err_seen_q <= 1'b0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      err_seen_q <= err_seen_d;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign err_seen = err_seen_q;

endmodule

// File: tb/tb_odd_bit_decoder.sv
// Drives identical traffic into an 8-bit-counter and a 2-bit-counter decoder and checks both against a queue model.
module tb_odd_bit_decoder;
  import odd_bit_pkg::*;

  logic       clk;
  logic       rst_n, clr, in_valid, out_ready, in_maj;
  logic [1:0] in_code;
  logic [7:0] err_cnt8;
  logic [1:0] err_cnt2;
  logic       err_seen8, err_seen2;

  odd_bit_decoder_if if8 ();
  odd_bit_decoder_if if2 ();

  assign if8.in_valid  = in_valid;
  assign if8.in_code   = in_code;
  assign if8.in_maj    = in_maj;
  assign if8.out_ready = out_ready;
  assign if2.in_valid  = in_valid;
  assign if2.in_code   = in_code;
  assign if2.in_maj    = in_maj;
  assign if2.out_ready = out_ready;

  odd_bit_decoder #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if8),
    .err_cnt(err_cnt8), .err_seen(err_seen8)
  );

  odd_bit_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(if2),
    .err_cnt(err_cnt2), .err_seen(err_seen2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] code;
    logic       maj;
    logic [2:0] word;
  } rec_t;

  rec_t q[$];
  int   m_cnt;
  bit   m_seen;
  int   vectors;
  int   miscompares;

  // Majority pattern with the named bit flipped, computed arithmetically.
  function automatic logic [2:0] ref_decode(input logic [1:0] code, input logic maj);
    int w;
    if (code == 2'd3) w = maj ? 7 : 0;
    else              w = maj ? (7 - (1 << code)) : (1 << code);
    return 3'(w);
  endfunction

  // Classifier: returns {code, maj} for a 3-bit word.
  function automatic logic [2:0] classify(input logic [2:0] w);
    int   ones;
    logic maj;
    logic [1:0] code;
    ones = int'(w[0]) + int'(w[1]) + int'(w[2]);
    maj  = (ones >= 2);
    code = CODE_NONE;
    for (int i = 0; i < 3; i++) if (w[i] != maj) code = 2'(i);
    return {code, maj};
  endfunction

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    logic exp_rdy;
    exp_rdy = rst_n && (q.size() < 2);
    chk("in_ready8", 32'(if8.in_ready), 32'(exp_rdy));
    chk("in_ready2", 32'(if2.in_ready), 32'(exp_rdy));
    chk("out_valid8", 32'(if8.out_valid), 32'(q.size() > 0));
    chk("out_valid2", 32'(if2.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out8", 32'(if8.out), 32'(q[0].word));
      chk("out2", 32'(if2.out), 32'(q[0].word));
      chk("roundtrip", 32'(classify(if8.out)), 32'({q[0].code, q[0].maj}));
    end
    chk("err_cnt8", 32'(err_cnt8), 32'(sat(m_cnt, 255)));
    chk("err_cnt2", 32'(err_cnt2), 32'(sat(m_cnt, 3)));
    chk("err_seen8", 32'(err_seen8), 32'(m_seen));
    chk("err_seen2", 32'(err_seen2), 32'(m_seen));
  endtask

  // One clock: drive inputs, predict push/pop, advance the model, check at the falling edge.
  task automatic cycle(input bit v, input logic [1:0] c, input logic m, input bit ordy, input bit cl);
    bit do_push, do_pop;
    in_valid  = v;
    in_code   = c;
    in_maj    = m;
    out_ready = ordy;
    clr       = cl;
    do_push   = v && rst_n && (q.size() < 2);
    do_pop    = rst_n && (q.size() > 0) && ordy;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_cnt  = 0;
      m_seen = 0;
    end else begin
      if (do_pop) q.delete(0);
      if (do_push) q.push_back('{code: c, maj: m, word: ref_decode(c, m)});
      if (cl) begin
        m_cnt  = 0;
        m_seen = 0;
      end else if (do_push && c != CODE_NONE) begin
        m_cnt++;
        m_seen = 1;
      end
    end
    @(negedge clk);
    check_state();
  endtask

  rec_t tbl[8];

  initial begin
    vectors = 0; miscompares = 0; m_cnt = 0; m_seen = 0;
    tbl[0] = '{2'b00, 1'b1, 3'b110};
    tbl[1] = '{2'b00, 1'b0, 3'b001};
    tbl[2] = '{2'b01, 1'b1, 3'b101};
    tbl[3] = '{2'b01, 1'b0, 3'b010};
    tbl[4] = '{2'b10, 1'b1, 3'b011};
    tbl[5] = '{2'b10, 1'b0, 3'b100};
    tbl[6] = '{2'b11, 1'b1, 3'b111};
    tbl[7] = '{2'b11, 1'b0, 3'b000};

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_code = 2'b00; in_maj = 1'b0; out_ready = 1'b0;
    cycle(0, 2'b00, 0, 0, 0);
    cycle(0, 2'b00, 0, 0, 0);
    chk("rst_out", 32'(if8.out), 32'd0);
    rst_n = 1'b1;
    cycle(0, 2'b00, 0, 0, 0);

    // All eight combinations, streamed with the sink always ready.
    for (int i = 0; i < 8; i++) begin
      cycle(1, tbl[i].code, tbl[i].maj, 1, 0);
      chk("tbl_word", 32'(if8.out), 32'(tbl[i].word));
    end
    cycle(0, 2'b00, 0, 1, 0);
    chk("tbl_err_cnt", 32'(err_cnt8), 32'd6);
    chk("tbl_err_seen", 32'(err_seen8), 32'd1);

    // Backpressure: third offer waits until a slot frees.
    cycle(1, 2'b00, 0, 0, 0);
    cycle(1, 2'b01, 0, 0, 0);
    chk("bp_full", 32'(if8.in_ready), 32'd0);
    cycle(1, 2'b10, 1, 0, 0);
    chk("bp_hold", 32'(if8.out), 32'(3'b001));
    cycle(1, 2'b10, 1, 1, 0);
    chk("bp_second", 32'(if8.out), 32'(3'b010));
    chk("bp_ready", 32'(if8.in_ready), 32'd1);
    cycle(1, 2'b10, 1, 1, 0);
    chk("bp_third", 32'(if8.out), 32'(3'b011));
    cycle(0, 2'b00, 0, 1, 0);
    chk("bp_drained", 32'(if8.out_valid), 32'd0);

    // Push and pop together at occupancy one.
    cycle(1, 2'b00, 1, 0, 0);
    cycle(1, 2'b01, 1, 1, 0);
    chk("pp_valid", 32'(if8.out_valid), 32'd1);
    chk("pp_word", 32'(if8.out), 32'(3'b101));
    cycle(0, 2'b00, 0, 1, 0);

    // Saturation of the narrow counter, then clear beating a mismatch push.
    cycle(0, 2'b00, 0, 1, 1);
    for (int k = 0; k < 5; k++) cycle(1, 2'(k % 3), 1'($urandom % 2), 1, 0);
    chk("sat_cnt2", 32'(err_cnt2), 32'd3);
    chk("sat_cnt8", 32'(err_cnt8), 32'd5);
    cycle(1, 2'b00, 1, 1, 1);
    chk("clr_cnt2", 32'(err_cnt2), 32'd0);
    chk("clr_seen2", 32'(err_seen2), 32'd0);
    cycle(0, 2'b00, 0, 1, 0);

    // Reset with the buffer full: stale words must never surface.
    cycle(1, 2'b00, 0, 0, 0);
    cycle(1, 2'b01, 1, 0, 0);
    chk("pre_rst_full", 32'(if8.in_ready), 32'd0);
    rst_n = 1'b0;
    cycle(0, 2'b00, 0, 0, 0);
    chk("rst_valid", 32'(if8.out_valid), 32'd0);
    chk("rst_cnt", 32'(err_cnt8), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cycle(0, 2'b00, 0, 1, 0);

    // Random traffic.
    for (int k = 0; k < 400; k++)
      cycle(($urandom % 4) != 0, 2'($urandom), 1'($urandom), ($urandom % 3) != 0, ($urandom % 25) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
